// File: rtl/count_udl_mod_pkg.sv
// rtl/count_udl_mod_pkg.sv - shared constants for the up/down/limit counter
package count_pkg;
   localparam logic MODE_WRAP     = 1'b0;
   localparam logic MODE_SAT      = 1'b1;
   localparam logic UP            = 1'b1;
   localparam logic DOWN          = 1'b0;
   localparam int   DEFAULT_WIDTH = 8;
   localparam int   DEFAULT_PRESC = 4;
endpackage

// File: rtl/count_udl_mod_if.sv
// rtl/count_udl_mod_if.sv - control/status bundle for count_udl_mod
interface count_udl_mod_if #(
   parameter int WIDTH = 8
) (
   input logic ck
);
   logic             en;
   logic             ud;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] lim;
   logic             mode;
   logic             clr_ovf;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             ovf;

   modport master (
      input  ck, cnt, tc, ovf,
      output en, ud, load, d, lim, mode, clr_ovf
   );

   modport slave (
      input  ck, en, ud, load, d, lim, mode, clr_ovf,
      output cnt, tc, ovf
   );
endinterface

// File: rtl/count_udl_mod_prescaler.sv
// rtl/count_udl_mod_prescaler.sv - free-running modulo-PRESC divider, ticks on its last state
module count_prescaler #(
   parameter int PRESC = 4
) (
   input  logic ck,
   input  logic reset_n,
   input  logic en,
   output logic tick
);
   localparam int PW = $clog2(PRESC);
   localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

   logic [PW-1:0] pcnt_q, pcnt_d;

   assign tick = (pcnt_q == LAST);

   always_comb begin
      pcnt_d = pcnt_q;
      if (en) begin
         pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      end
   end

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end
endmodule

// File: rtl/count_udl_mod.sv
// rtl/count_udl_mod.sv - up/down counter with runtime limit, wrap/saturate, sticky overflow
// Optional prescaler on the step enable: define COUNT_UDL_PRESC_EN.
module count_udl_mod
   import count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int PRESC = DEFAULT_PRESC
) (
   input  logic             ck,
   input  logic             reset_n,
   input  logic             en,
   input  logic             ud,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] lim,
   input  logic             mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step_en;
   logic             boundary;

   if (PRESC < 2) begin : g_bad_presc
      $error("count_udl_mod: PRESC must be at least 2");
   end

`ifdef COUNT_UDL_PRESC_EN
   logic tick;

   count_prescaler #(
      .PRESC(PRESC)
   ) u_presc (
      .ck      (ck),
      .reset_n (reset_n),
      .en      (en),
      .tick    (tick)
   );

   assign step_en = en & tick;
`else
   assign step_en = en;
`endif

   always_comb begin
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (load) begin
         cnt_d = (d > lim) ? lim : d;
      end else if (step_en) begin
         if (ud == UP) begin
            // >= so a count stranded above a lowered limit still hits the boundary
            if (cnt_q >= lim) begin
               boundary = 1'b1;
               cnt_d    = (mode == MODE_SAT) ? lim : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (cnt_q == '0) begin
               boundary = 1'b1;
               cnt_d    = (mode == MODE_SAT) ? '0 : lim;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
      tc_d  = boundary;
      ovf_d = boundary | (ovf_q & ~clr_ovf);
   end

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;
endmodule
